// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply.
// Define ALU_MC_DIV_EN to add the iterative restoring divider on opcode 0110.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             ar_flag,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);
    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    C_END = CW'(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ITER = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0011, OP_SUB = 4'b0100, OP_MUL = 4'b0101,
                           OP_DIV = 4'b0110, OP_AND = 4'b0111, OP_OR  = 4'b1000,
                           OP_XOR = 4'b1001, OP_SHL = 4'b1010, OP_SHR = 4'b1011;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic             ar_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, qr_q;

    logic             multi;
    logic [WIDTH:0]   add_r, mul_sum;
    logic [WIDTH-1:0] sub_r, sc_res;
    logic [2*WIDTH-1:0] rot_tmp;
    logic             big, sc_c, sc_o;
    logic [3:0]       sc_flags, it_flags;

`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    assign multi    = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign rem_sh   = {acc_q, qr_q[WIDTH-1]};
    // remainder after a successful subtract is < divisor, so W bits suffice
    assign div_ge   = rem_sh >= {1'b0, b_q};
    assign div_diff = rem_sh[WIDTH-1:0] - b_q;
    assign it_flags = (op_q == OP_DIV)
                    ? {b_q == '0, 1'b0, qr_q[WIDTH-1], qr_q == '0}
                    : {1'b0, |acc_q, qr_q[WIDTH-1], qr_q == '0};
`else
    assign multi    = (opcode == OP_MUL);
    assign it_flags = {1'b0, |acc_q, qr_q[WIDTH-1], qr_q == '0};
`endif

    assign mul_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, a_q} : '0);

    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_o    = 1'b0;
        add_r   = {1'b0, a_q} + {1'b0, b_q};
        sub_r   = a_q - b_q;
        rot_tmp = {a_q, a_q} << b_q[AW-1:0];
        big     = (b_q >= W_VAL);
        case (op_q)
            OP_ADD: begin
                sc_res = add_r[WIDTH-1:0];
                sc_c   = add_r[WIDTH];
                sc_o   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_r;
                sc_c   = a_q < b_q;
                sc_o   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: sc_res = a_q & b_q;
            OP_OR:  sc_res = a_q | b_q;
            OP_XOR: sc_res = a_q ^ b_q;
            OP_SHL: begin
                if (ar_q)     sc_res = rot_tmp[2*WIDTH-1:WIDTH];
                else if (big) sc_res = '0;
                else          sc_res = a_q << b_q[AW-1:0];
            end
            OP_SHR: begin
                if (ar_q) sc_res = big ? {WIDTH{a_q[WIDTH-1]}}
                                       : $unsigned($signed(a_q) >>> b_q[AW-1:0]);
                else      sc_res = big ? '0 : a_q >> b_q[AW-1:0];
            end
            default: sc_res = '0;
        endcase
        sc_flags = {sc_o, sc_c, sc_res[WIDTH-1], sc_res == '0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            ar_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            qr_q  <= '0;
            out   <= '0;
            flags <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy while idle marks a single-cycle op waiting to retire
                    if (busy) begin
                        out   <= sc_res;
                        flags <= sc_flags;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (start) begin
                        op_q  <= opcode;
                        ar_q  <= ar_flag;
                        a_q   <= src1;
                        b_q   <= src2;
                        acc_q <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef ALU_MC_DIV_EN
                        qr_q  <= (opcode == OP_DIV) ? src1 : src2;
`else
                        qr_q  <= src2;
`endif
                        if (multi) state <= S_ITER;
                    end
                end
                default: begin
                    if (cnt == C_END) begin
                        out   <= qr_q;
                        flags <= it_flags;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef ALU_MC_DIV_EN
                        if (op_q == OP_DIV) begin
                            acc_q <= div_ge ? div_diff : rem_sh[WIDTH-1:0];
                            qr_q  <= {qr_q[WIDTH-2:0], div_ge};
                        end else begin
                            acc_q <= mul_sum[WIDTH:1];
                            qr_q  <= {mul_sum[0], qr_q[WIDTH-1:1]};
                        end
`else
                        acc_q <= mul_sum[WIDTH:1];
                        qr_q  <= {mul_sum[0], qr_q[WIDTH-1:1]};
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width in bits (legal values 8..32, power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 opcode  input  4  operation select, latched on accepted start.
REQ-006 ar_flag  input  1  shift mode select, latched on accepted start.
REQ-007 src1  input  WIDTH  operand A, latched on accepted start.
REQ-008 src2  input  WIDTH  operand B, latched on accepted start.
REQ-009 out  output  WIDTH  registered result; holds until the next completion.
REQ-010 flags  output  4  registered {O,C,N,Z}; updated only on completion.
REQ-011 busy  output  1  high from start acceptance until completion.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 States SHALL be IDLE and ITER; start in IDLE latches operands, sets busy, enters ITER (multi-cycle ops) or stays IDLE and completes next edge (single-cycle ops).
REQ-014 Single-cycle ops SHALL complete at the edge after acceptance: out, flags and done=1 update together; busy=0 at that edge.
REQ-015 Multiply (0110 excluded) 0101 SHALL be iterative shift-add, WIDTH iterations; completion at acceptance edge + WIDTH + 1.
REQ-016 Divide 0110 SHALL be unsigned restoring, WIDTH iterations, same latency as multiply; quotient to out, remainder discarded.
REQ-017 Opcodes: 0011 add, 0100 sub, 0101 mul (low WIDTH bits), 0110 div, 0111 and, 1000 or, 1001 xor, 1010 shift left (ar_flag=1: rotate left), 1011 shift right (ar_flag=1: arithmetic).
REQ-018 Shift amount SHALL be src2 unsigned; amount >= WIDTH gives 0 (logical), all sign bits (arithmetic), amount mod WIDTH (rotate).
REQ-019 Unlisted opcodes SHALL complete single-cycle with out=0, flags=0001.
REQ-020 N = out MSB; Z = (out==0) for every op.
REQ-021 C: add carry-out; sub borrow (src1<src2 unsigned); mul any nonzero bit in the high WIDTH product bits; all others 0.
REQ-022 O: add signed overflow; sub signed overflow (operand signs differ, result sign != src1 sign); div by zero 1; all others 0.
REQ-023 Division by zero SHALL return out all ones, O=1, still WIDTH+1 cycle latency.
REQ-024 start while busy SHALL be ignored with no effect on the operation in flight.
REQ-025 start in the cycle done=1 SHALL be accepted (back-to-back, no idle bubble).
REQ-026 Input changes after acceptance SHALL NOT affect the result.

Reset
REQ-027 rst low SHALL immediately force out=0, flags=0000, busy=0, done=0, state IDLE, iteration counter 0.
REQ-028 Reset mid-operation SHALL abort it with no done pulse; first start after rst release is accepted normally.

Configuration
REQ-029 Macro ALU_MC_DIV_EN defined: divider present per REQ-016/REQ-023.
REQ-030 ALU_MC_DIV_EN undefined: no divider logic; opcode 0110 behaves as unlisted per REQ-019 (single-cycle, out=0, flags 0001).

Verification (WIDTH=16)
REQ-031 add 0x7FFF+0x0001 -> out 0x8000, flags 1010, done 1 cycle after acceptance.
REQ-032 mul 0x0100*0x0100 -> out 0x0000, flags 0101, done 17 cycles after acceptance; second start pulsed mid-operation ignored.
REQ-033 div 100/7 -> out 0x000E, flags 0000, 17 cycles; div 5/0 -> out 0xFFFF, flags 1010 (without ALU_MC_DIV_EN: out 0, flags 0001, 1 cycle).
REQ-034 shr ar_flag=1 0x8000 by 4 -> 0xF800, flags 0010; rol 0x8001 by 17 -> 0x0003, flags 0000.
REQ-035 sub 0x0003-0x0005 -> out 0xFFFE, flags 0110; immediately followed by start on done cycle with and 0xF0F0&0x0F0F -> out 0x0000, flags 0001 one cycle later.
REQ-036 rst low 5 cycles into a mul -> out 0, flags 0000, busy 0, no done; new add 1+1 after release -> out 0x0002.
